// File: rtl/mem_rr_pkg.sv
// mem_rr_pkg: shared FSM state type and one-hot decode helper for the memory scheduler
package mem_rr_pkg;
  typedef enum logic [0:0] {ST_INIT, ST_RUN} state_e;
  function automatic int onehot2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) idx = i;
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: pointer-based round-robin pick among req, pointer moves past each grant
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : request vector
//   grant    : one-hot grant (combinational)
//   gnt_idx  : index of the granted bit
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] gnt_idx
);
  import mem_rr_pkg::*;
  logic [$clog2(N)-1:0] r_ptr;
  // scan from farthest to nearest offset so the request closest to the pointer wins
  always_comb begin
    grant = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(r_ptr) + i) % N]) begin
        grant = '0;
        grant[(int'(r_ptr) + i) % N] = 1'b1;
      end
  end
  assign gnt_idx = $clog2(N)'(onehot2idx(32'(grant)));
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (|grant) r_ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
  end
endmodule

// File: rtl/mem_rr_scheduler.sv
// mem_rr_scheduler: round-robin shared single-port memory, cleared by a sweep after reset
//   clk, rst   : clock, synchronous active-high reset
//   req_*      : per-requester valid / write-enable / address / write data
//   req_ready  : one-hot grant, transfer on valid & ready
//   rsp_valid  : one-hot read response, one cycle after the read grant
//   rsp_data   : read data, holds last value when no response
//   init_done  : high once the clear sweep has finished
module mem_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0]             req_we,
  input  logic [NREQ-1:0][AW-1:0]     req_addr,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_wdata,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             rsp_valid,
  output logic [WIDTH-1:0]            rsp_data,
  output logic                        init_done
);
  import mem_rr_pkg::*;
  localparam int IW = $clog2(NREQ);
  state_e r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_addr;
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [NREQ-1:0] w_req, w_grant;
  logic [IW-1:0] w_gidx;
  logic w_run, w_wr, w_rd;
  assign w_run = r_state == ST_RUN;
  // requests are invisible to the arbiter until the sweep is done
  assign w_req = req_valid & {NREQ{w_run}};
  rr_arbiter #(.N(NREQ)) u_arb (
    .clk(clk), .rst(rst), .req(w_req), .grant(w_grant), .gnt_idx(w_gidx)
  );
  assign w_wr = |w_grant & req_we[w_gidx];
  assign w_rd = |w_grant & ~req_we[w_gidx];
  assign w_addr = w_run ? req_addr[w_gidx] : r_ptr;
  assign req_ready = w_grant;
  assign init_done = w_run;
  always_comb begin
    w_state_nxt = (r_state == ST_INIT && r_ptr == AW'(DEPTH - 1)) ? ST_RUN : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_INIT;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      if (!w_run) r_ptr <= r_ptr + 1'b1;
      rsp_valid <= w_rd ? w_grant : '0;
      if (w_rd) rsp_data <= r_mem[w_addr];
    end
  end
  // single write port: sweep clears during INIT, granted writes during RUN
  always_ff @(posedge clk) begin
    if (!rst && (!w_run || w_wr)) r_mem[w_addr] <= w_run ? req_wdata[w_gidx] : '0;
  end
endmodule

// File: tb/tb_mem_rr_scheduler.sv
// tb_mem_rr_scheduler: directed and random stimulus checked against a behavioural model
module tb_mem_rr_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid = '0, req_we = '0;
  logic [3:0][1:0] req_addr = '0;
  logic [3:0][7:0] req_wdata = '0;
  logic [3:0] req_ready, rsp_valid;
  logic [7:0] rsp_data;
  logic init_done;
  int vectors = 0, miscompares = 0;
  bit m_run;
  int m_left, m_ptr;
  logic [7:0] m_mem [4];
  logic [3:0] m_rv;
  logic [7:0] m_rd;
  mem_rr_scheduler #(.NREQ(4), .DEPTH(4), .WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .init_done(init_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input logic [3:0] v, input logic [3:0] we, input logic [7:0] a, input logic [31:0] wd);
    req_valid = v;
    req_we = we;
    req_addr = a;
    req_wdata = wd;
  endtask
  task automatic step();
    int g;
    logic [3:0] eg;
    g = -1;
    eg = '0;
    if (m_run)
      for (int i = 0; i < 4; i++)
        if (g < 0 && req_valid[(m_ptr + i) % 4]) g = (m_ptr + i) % 4;
    if (g >= 0) eg[g] = 1'b1;
    #1;
    chk("req_ready", req_ready, eg);
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_data", rsp_data, m_rd);
    chk("init_done", init_done, m_run);
    @(posedge clk);
    if (rst) begin
      m_run = 0; m_left = 4; m_ptr = 0; m_rv = '0; m_rd = '0;
    end else if (!m_run) begin
      m_mem[4 - m_left] = '0;
      m_left--;
      m_run = m_left == 0;
      m_rv = '0;
    end else begin
      m_rv = '0;
      if (g >= 0) begin
        if (req_we[g]) m_mem[req_addr[g]] = req_wdata[g];
        else begin
          m_rv[g] = 1'b1;
          m_rd = m_mem[req_addr[g]];
        end
        m_ptr = (g + 1) % 4;
      end
    end
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    m_run = 0; m_left = 4; m_ptr = 0; m_rv = '0; m_rd = '0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("init_low", init_done, 1'b0);
      step();
    end
    chk("init_high", init_done, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drv(4'b0001, 4'b0000, 8'(i), 0);
      step();
      drv(4'b0000, 4'b0000, 0, 0);
      #1 chk("clear_read", rsp_data, 8'h00);
      step();
    end
    drv(4'b0001, 4'b0001, 8'h02, 32'h0000_00A5);
    step();
    drv(4'b0010, 4'b0000, 8'h08, 0);
    step();
    drv(4'b0000, 4'b0000, 0, 0);
    #1 chk("t2_valid", rsp_valid, 4'b0010);
    chk("t2_data", rsp_data, 8'hA5);
    step();
    drv(4'b1010, 4'b0000, 8'h00, 0);
    #1 chk("t4_first", req_ready, 4'b1000);
    step();
    drv(4'b0010, 4'b0000, 8'h00, 0);
    #1 chk("t4_second", req_ready, 4'b0010);
    step();
    drv(4'b1000, 4'b0000, 8'h00, 0);
    step();
    drv(4'b1111, 4'b0000, 8'b11_10_01_00, 0);
    for (int i = 0; i < 8; i++) begin
      #1 chk("t3_grant", req_ready, 4'b0001 << (i % 4));
      step();
      chk("t3_rsp", rsp_valid, 4'b0001 << (i % 4));
    end
    drv(4'b0001, 4'b0001, 8'h01, 32'h0000_003C);
    step();
    drv(4'b0100, 4'b0000, 8'h10, 0);
    step();
    drv(4'b0000, 4'b0000, 0, 0);
    #1 chk("t5_data", rsp_data, 8'h3C);
    step();
    drv(4'b0010, 4'b0000, 8'h08, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drv(4'b0000, 4'b0000, 0, 0);
    #1 chk("t6_norsp", rsp_valid, 4'b0000);
    for (int i = 0; i < 4; i++) step();
    drv(4'b0010, 4'b0000, 8'h08, 0);
    step();
    drv(4'b0000, 4'b0000, 0, 0);
    #1 chk("t6_cleared", rsp_data, 8'h00);
    step();
    for (int i = 0; i < 400; i++) begin
      drv(4'($urandom), 4'($urandom), 8'($urandom), $urandom);
      rst = $urandom_range(0, 99) == 0;
      step();
    end
    rst = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
